alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Decode-to-execute stage of the 5-stage RV32I pipeline: decodes the 32-bit instruction from IF/ID into the 4-bit `alu_control` code and datapath enables consumed by the ALU in EX, and holds them in the ID/EX pipeline register. It is the producing end of the ALU operation-select interface. It also owns the valid/ready handshake between ID and EX, flush, and load-use hazard stalling.

## Interface
- `XLEN`, 32, datapath/immediate width
- `clk` input 1 — rising-edge clock
- `rst_n` input 1 — reset, asynchronous, active-low
- `id_valid` input 1 — `id_instr` holds a valid instruction
- `id_instr` input 32 — instruction word
- `id_ready` output 1 — stage accepts `id_instr` this cycle (combinational)
- `ex_ready` input 1 — EX consumes the current ID/EX contents
- `flush` input 1 — kill ID/EX contents (taken branch)
- `ex_valid` output 1 — ID/EX register holds a live instruction
- `ex_alu_control` output 4 — ALU op select
- `ex_alu_src_imm` output 1 — operand2 = `ex_imm` (else rs2)
- `ex_imm` output XLEN — sign-extended immediate
- `ex_rs1`, `ex_rs2`, `ex_rd` output 5 each — register indices
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` output 1 each
- `ex_branch` output 1; `ex_branch_ne` output 1 — branch on !zero_flag instead of zero_flag
- `illegal` output 1 — one-cycle pulse (only with ILLEGAL_INSN_EN)

## Operation
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101.
- Opcode 0110011 (R): f3 000/f7 0000000 ADD, f3 000/f7 0100000 SUB, 111 AND, 110 OR, 100 XOR, 010 SLT (f7 must be 0); reg_write=1.
- Opcode 0010011 (I): f3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT; imm = sext(instr[31:20]); alu_src_imm=1, reg_write=1.
- Opcode 0000011, f3 010 (LW): ADD, I-imm, alu_src_imm, mem_read, reg_write.
- Opcode 0100011, f3 010 (SW): ADD, imm = sext({instr[31:25],instr[11:7]}), alu_src_imm, mem_write.
- Opcode 1100011, f3 000 BEQ / 001 BNE: SUB, alu_src_imm=0, branch=1, branch_ne=f3[0], imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- Any other encoding is illegal (see Configuration).
- rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7] always captured; rd forced 0 when reg_write=0.
- Hazard: `hz = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs1 | ex_rd==rs2)` of incoming instruction (rs2 compared only for R, S, B formats).
- `id_ready = (!ex_valid | ex_ready) & !hz`.

## Timing
- Reset: every output 0 (`ex_valid`=0, `ex_alu_control`=0000, all enables 0, `illegal`=0).
- Latency: 1 cycle; instruction accepted at edge N (id_valid & id_ready) appears on ex_* after edge N.
- EX holds (all ex_* stable) while ex_valid & !ex_ready.
- ex_ready & !accept: ex_valid←0 (bubble). Hazard cycle with ex_ready=1 therefore inserts exactly one bubble; instruction accepted next cycle.
- flush: ex_valid←0 at next edge, overrides hold and accept; `id_ready` unaffected (IF/ID flushed upstream, id_valid deasserted by owner).
- Control outputs of a bubble are zeroed (enables 0) so downstream never sees stale writes.
- Reset asserted mid-stall/mid-hold: immediate return to reset values.

## Configuration
- `ILLEGAL_INSN_EN` defined: illegal instruction is accepted, ID/EX loads a bubble, `illegal` pulses 1 cycle after acceptance; flush in the same cycle suppresses the pulse.
- Undefined: illegal instruction loads as valid NOP (ADD, all write/mem/branch enables 0); `illegal` tied 0.

## Structure
- Package `rv_pkg`: ALU code localparams (ALU_ADD…ALU_SLT), opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH), funct3/funct7 constants; shared with the ALU and control unit.
- Sub-module `alu_ctrl_decoder`: purely combinational instr → control bundle + illegal flag; top holds hazard logic and ID/EX register.

## Test plan
- Reset release, no id_valid → ex_valid=0, all outputs 0, id_ready=1.
- SUB x3,x1,x2 (0x402081B3) then ADDI x5,x0,-1 (0xFFF00293) with ex_ready=1 → alu_control 0001, reg_write=1, rd=3; then 0000, imm=0xFFFFFFFF, alu_src_imm=1, rd=5.
- LW x6,0(x1) then ADD x7,x6,x2 → id_ready=0 one cycle, one bubble (ex_valid=0), ADD appears next cycle; with rd=x0 load no stall.
- ex_ready=0 for 3 cycles holding BNE (0x00209463) → ex_* stable, branch=1, branch_ne=1, imm=8, id_ready=0 throughout.
- flush while holding instruction and ex_ready=0 → ex_valid=0 next cycle.
- Instruction 0x00000000: with ILLEGAL_INSN_EN illegal pulses 1 cycle, ex_valid=0; without, ex_valid=1, all enables 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: ALU operation codes, opcodes, funct fields
// and the control bundle that travels from ID into the ID/EX register.
package rv_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       alu_src_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
    } ctrl_t;

    typedef struct packed {
        logic       vld;
        ctrl_t      ctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } stage_t;

    // Maps the arithmetic/logic funct3 values shared by R and I formats.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
        case (f3)
            F3_AND:  return ALU_AND;
            F3_OR:   return ALU_OR;
            F3_XOR:  return ALU_XOR;
            F3_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic f3_is_alu(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_AND) || (f3 == F3_OR) ||
               (f3 == F3_XOR) || (f3 == F3_SLT);
    endfunction

endpackage

// File: rtl/alu_ctrl_decoder.sv
// Combinational RV32I subset decoder: instruction word to ALU control bundle,
// sign-extended immediate, rs2-usage flag and illegal-encoding flag.
module alu_ctrl_decoder
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   [31:0]     instr,
    output ctrl_t                             ctrl,
    output logic signed            [XLEN-1:0] imm,
    output logic                              uses_rs2,
    output logic                              illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [XLEN-1:0] imm_i, imm_s, imm_b;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};

    always_comb begin
        ctrl     = '0;
        imm      = '0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_R: begin
                uses_rs2       = 1'b1;
                ctrl.reg_write = 1'b1;
                if (!f3_is_alu(f3)) begin
                    illegal = 1'b1;
                end else if (f3 == F3_ADD && f7 == F7_SUB) begin
                    ctrl.alu_control = ALU_SUB;
                end else if (f7 == F7_BASE) begin
                    ctrl.alu_control = alu_from_f3(f3);
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                illegal          = !f3_is_alu(f3);
                ctrl.alu_control = alu_from_f3(f3);
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                imm              = imm_i;
            end
            OP_LOAD: begin
                illegal          = (f3 != F3_LW);
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.reg_write   = 1'b1;
                imm              = imm_i;
            end
            OP_STORE: begin
                illegal          = (f3 != F3_SW);
                uses_rs2         = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
                imm              = imm_s;
            end
            OP_BRANCH: begin
                illegal          = (f3 != F3_BEQ) && (f3 != F3_BNE);
                uses_rs2         = 1'b1;
                ctrl.alu_control = ALU_SUB;
                ctrl.branch      = 1'b1;
                ctrl.branch_ne   = f3[0];
                imm              = imm_b;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal encodings collapse to an ADD with every side effect disabled.
        if (illegal) begin
            ctrl     = '0;
            imm      = '0;
            uses_rs2 = 1'b0;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// ID/EX stage: decode, load-use hazard stall, valid/ready handshake and flush.
// Optional macro ILLEGAL_INSN_EN turns illegal encodings into bubbles with a pulse.
module alu_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [31:0]            id_instr,
    output logic                   id_ready,
    input  logic                   ex_ready,
    input  logic                   flush,
    output logic                   ex_valid,
    output logic [3:0]             ex_alu_control,
    output logic                   ex_alu_src_imm,
    output logic signed [XLEN-1:0] ex_imm,
    output logic [4:0]             ex_rs1,
    output logic [4:0]             ex_rs2,
    output logic [4:0]             ex_rd,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_branch,
    output logic                   ex_branch_ne,
    output logic                   illegal
);

    ctrl_t                  dec_ctrl;
    logic signed [XLEN-1:0] dec_imm;
    logic                   dec_uses_rs2;
    logic                   dec_illegal;

    logic [4:0] rs1, rs2, rd;
    logic       hz, hold, accept, load_bubble;

    stage_t                 st_p1, st_nxt;
    logic signed [XLEN-1:0] imm_p1, imm_nxt;

    alu_ctrl_decoder #(.XLEN(XLEN)) u_dec (
        .instr    (id_instr),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (dec_illegal)
    );

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign rd  = id_instr[11:7];

    // Load in EX whose result the incoming instruction needs next cycle.
    assign hz = st_p1.vld && st_p1.ctrl.mem_read && (st_p1.rd != 5'd0) &&
                ((st_p1.rd == rs1) || (dec_uses_rs2 && (st_p1.rd == rs2)));

    assign hold     = st_p1.vld && !ex_ready;
    assign id_ready = (!st_p1.vld || ex_ready) && !hz;
    assign accept   = id_valid && id_ready;

`ifdef ILLEGAL_INSN_EN
    assign load_bubble = dec_illegal;
`else
    assign load_bubble = 1'b0;
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

    // Anything that is not a fresh legal accept becomes a fully zeroed bubble.
    always_comb begin
        st_nxt  = '0;
        imm_nxt = '0;
        if (!flush && accept && !load_bubble) begin
            st_nxt.vld  = 1'b1;
            st_nxt.ctrl = dec_ctrl;
            st_nxt.rs1  = rs1;
            st_nxt.rs2  = rs2;
            st_nxt.rd   = dec_ctrl.reg_write ? rd : 5'd0;
            imm_nxt     = dec_imm;
        end
    end

    // ---- ID/EX register (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_p1  <= '0;
            imm_p1 <= '0;
        end else if (flush || !hold) begin
            st_p1  <= st_nxt;
            imm_p1 <= imm_nxt;
        end
    end

`ifdef ILLEGAL_INSN_EN
    logic illegal_p1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_p1 <= 1'b0;
        end else begin
            illegal_p1 <= accept && dec_illegal && !flush;
        end
    end
    assign illegal = illegal_p1;
`else
    assign illegal = 1'b0;
`endif

    assign ex_valid       = st_p1.vld;
    assign ex_alu_control = st_p1.ctrl.alu_control;
    assign ex_alu_src_imm = st_p1.ctrl.alu_src_imm;
    assign ex_reg_write   = st_p1.ctrl.reg_write;
    assign ex_mem_read    = st_p1.ctrl.mem_read;
    assign ex_mem_write   = st_p1.ctrl.mem_write;
    assign ex_branch      = st_p1.ctrl.branch;
    assign ex_branch_ne   = st_p1.ctrl.branch_ne;
    assign ex_rs1         = st_p1.rs1;
    assign ex_rs2         = st_p1.rs2;
    assign ex_rd          = st_p1.rd;
    assign ex_imm         = imm_p1;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage (ILLEGAL_INSN_EN aware).
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        id_ready;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_alu_control;
    logic        ex_alu_src_imm;
    logic signed [31:0] ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_branch_ne;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_ready       (id_ready),
        .ex_ready       (ex_ready),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_alu_control (ex_alu_control),
        .ex_alu_src_imm (ex_alu_src_imm),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_branch      (ex_branch),
        .ex_branch_ne   (ex_branch_ne),
        .illegal        (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        id_valid = 1'b0;
        id_instr = 32'h0;
        ex_ready = 1'b1;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_alu", ex_alu_control, 0);
        check("rst_imm", ex_imm, 0);
        check("rst_enables", {ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne}, 0);
        check("rst_illegal", illegal, 0);
        check("rst_id_ready", id_ready, 1);

        // SUB x3,x1,x2 then ADDI x5,x0,-1
        id_valid = 1'b1;
        id_instr = 32'h402081B3;
        step();
        check("sub_valid", ex_valid, 1);
        check("sub_alu", ex_alu_control, 4'b0001);
        check("sub_regw", ex_reg_write, 1);
        check("sub_rd", ex_rd, 3);
        check("sub_rs", {ex_rs1, ex_rs2}, {5'd1, 5'd2});
        check("sub_srcimm", ex_alu_src_imm, 0);
        id_instr = 32'hFFF00293;
        step();
        check("addi_alu", ex_alu_control, 4'b0000);
        check("addi_imm", ex_imm, 32'hFFFFFFFF);
        check("addi_srcimm", ex_alu_src_imm, 1);
        check("addi_rd", ex_rd, 5);

        // LW x6,0(x1) followed by dependent ADD x7,x6,x2
        id_instr = 32'h0000A303;
        step();
        check("lw_memrd", ex_mem_read, 1);
        check("lw_rd", ex_rd, 6);
        check("lw_regw_src", {ex_reg_write, ex_alu_src_imm}, 2'b11);
        id_instr = 32'h002303B3;
        #1;
        check("hz_id_ready", id_ready, 0);
        step();
        check("hz_bubble_valid", ex_valid, 0);
        check("hz_bubble_ctrl", {ex_reg_write, ex_mem_read}, 0);
        check("hz_ready_again", id_ready, 1);
        step();
        check("hz_add_valid", ex_valid, 1);
        check("hz_add_rd", ex_rd, 7);
        check("hz_add_rs", {ex_rs1, ex_rs2}, {5'd6, 5'd2});

        // LW x0 never stalls its consumer
        id_instr = 32'h0000A003;
        step();
        check("lw0_rd", ex_rd, 0);
        id_instr = 32'h002003B3;
        #1;
        check("lw0_no_stall", id_ready, 1);
        step();
        check("lw0_next_rd", ex_rd, 7);

        // SLT and SW coverage
        id_instr = 32'h0020A233;
        step();
        check("slt_alu", ex_alu_control, 4'b0101);
        id_instr = 32'h0020A623;
        step();
        check("sw_memwr", ex_mem_write, 1);
        check("sw_imm", ex_imm, 12);
        check("sw_rd_regw", {ex_rd, ex_reg_write}, 0);

        // BNE x1,x2,+8 then hold 3 cycles
        id_instr = 32'h00209463;
        step();
        check("bne_branch", {ex_branch, ex_branch_ne}, 2'b11);
        check("bne_imm", ex_imm, 8);
        check("bne_alu", ex_alu_control, 4'b0001);
        check("bne_rd", ex_rd, 0);
        ex_ready = 1'b0;
        id_instr = 32'hFFF00293;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", ex_valid, 1);
            check("hold_branch", {ex_branch, ex_branch_ne}, 2'b11);
            check("hold_imm", ex_imm, 8);
            check("hold_id_ready", id_ready, 0);
        end

        // Flush overrides hold
        id_valid = 1'b0;
        flush    = 1'b1;
        step();
        check("flush_valid", ex_valid, 0);
        check("flush_branch", ex_branch, 0);
        flush = 1'b0;

        // Reset during a hold
        ex_ready = 1'b1;
        id_valid = 1'b1;
        id_instr = 32'h0020A623;
        step();
        ex_ready = 1'b0;
        id_valid = 1'b0;
        step();
        check("prehold_memwr", ex_mem_write, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", ex_valid, 0);
        check("async_rst_memwr", ex_mem_write, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        ex_ready = 1'b1;

        // All-zero instruction word
        id_valid = 1'b1;
        id_instr = 32'h00000000;
        step();
`ifdef ILLEGAL_INSN_EN
        check("ill_valid", ex_valid, 0);
        check("ill_pulse", illegal, 1);
        id_valid = 1'b0;
        step();
        check("ill_pulse_end", illegal, 0);
`else
        check("ill_nop_valid", ex_valid, 1);
        check("ill_nop_alu", ex_alu_control, 0);
        check("ill_nop_enables", {ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne}, 0);
        check("ill_tied", illegal, 0);
        id_valid = 1'b0;
        step();
        check("ill_nop_drain", ex_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
